// File: rtl/ex_result_buffer.sv
// ex_result_buffer
//   Execute-to-memory stage register that sits right after the ALU. It captures
//   the ALU flags together with the destination register and write-enable, and
//   turns a trapping overflow into an exception flag with the register write
//   squashed. A 2-entry skid buffer keeps the execute stage decoupled from a
//   stalling memory stage. A saturating counter tracks trapped overflows.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   flush               synchronous discard of all buffered beats
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_*                ALU Result/Zero/Overflow/CarryOut, rd, reg_write, trap_ov
//   out_valid/out_ready downstream handshake
//   out_*               buffered beat; out_exc = trapped overflow
//   ov_count            saturating count of trapped overflows
//
// state | meaning
// EMPTY | no beat held, outputs not valid
// ONE   | MAIN holds the beat being presented downstream
// FULL  | MAIN presented, SKID holds the next beat, upstream stalled
module ex_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_zero,
    input  logic                  in_overflow,
    input  logic                  in_carryout,
    input  logic [4:0]            in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_trap_ov,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_carryout,
    output logic [4:0]            out_rd,
    output logic                  out_reg_write,
    output logic                  out_exc,
    output logic [CNT_W-1:0]      ov_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  carryout;
        logic [4:0]            rd;
        logic                  reg_write;
        logic                  exc;
    } beat_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    beat_t            main_q, main_d;
    beat_t            skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] ov_count_q, ov_count_d;

    beat_t in_beat;
    logic  exc;
    logic  accept;
    logic  pop;

    // Overflow is consumed here: it only survives as the exception flag.
    always_comb begin
        exc                = in_trap_ov & in_overflow;
        in_beat.result     = in_result;
        in_beat.zero       = in_zero;
        in_beat.carryout   = in_carryout;
        in_beat.rd         = in_rd;
        in_beat.reg_write  = in_reg_write & ~exc;
        in_beat.exc        = exc;
    end

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        ov_count_d = ov_count_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_beat;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_d  = in_beat;
                        state_d = FULL;
                    end else if (accept && pop) begin
                        main_d  = in_beat;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // accept already excludes flush, so a dropped beat is never counted
        if (accept && exc && (ov_count_q != CNT_MAX)) begin
            ov_count_d = ov_count_q + 1'b1;
        end

        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            ov_count_q <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            ov_count_q <= ov_count_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_result    = main_q.result;
    assign out_zero      = main_q.zero;
    assign out_carryout  = main_q.carryout;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write;
    assign out_exc       = main_q.exc;
    assign ov_count      = ov_count_q;

endmodule

// File: tb/tb_ex_result_buffer.sv
module tb_ex_result_buffer;

    localparam int DW    = 32;
    localparam int CNT_W = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic          in_zero;
    logic          in_overflow;
    logic          in_carryout;
    logic [4:0]    in_rd;
    logic          in_reg_write;
    logic          in_trap_ov;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_zero;
    logic          out_carryout;
    logic [4:0]    out_rd;
    logic          out_reg_write;
    logic          out_exc;
    logic [CNT_W-1:0] ov_count;

    int n_cmp = 0;
    int n_err = 0;

    ex_result_buffer #(.DATA_WIDTH(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_zero(in_zero), .in_overflow(in_overflow),
        .in_carryout(in_carryout), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_trap_ov(in_trap_ov),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_carryout(out_carryout),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_exc(out_exc),
        .ov_count(ov_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [DW-1:0] r, input logic [4:0] rd,
                        input logic rw, input logic ovf, input logic trap);
        in_valid     = v;
        in_result    = r;
        in_rd        = rd;
        in_reg_write = rw;
        in_overflow  = ovf;
        in_trap_ov   = trap;
        in_zero      = (r == '0);
        in_carryout  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        beat(1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ov_count", ov_count, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_rw", out_reg_write, 0);
        chk("rst_out_exc", out_exc, 0);
        rst = 1'b1;
        tick();

        // single beat, one-cycle latency
        out_ready = 1'b1;
        beat(1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        beat(1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("single_valid", out_valid, 1);
        chk("single_result", out_result, 32'h5);
        chk("single_rd", out_rd, 3);
        chk("single_rw", out_reg_write, 1);
        chk("single_exc", out_exc, 0);
        tick();
        chk("single_empty_valid", out_valid, 0);
        chk("single_empty_ready", in_ready, 1);

        // trapping overflow vs addu
        beat(1'b1, 32'h8000_0000, 5'd4, 1'b1, 1'b1, 1'b1);
        tick();
        beat(1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("trap_exc", out_exc, 1);
        chk("trap_rw", out_reg_write, 0);
        chk("trap_result", out_result, 32'h8000_0000);
        chk("trap_count", ov_count, 1);
        tick();
        beat(1'b1, 32'h8000_0000, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        beat(1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("addu_exc", out_exc, 0);
        chk("addu_rw", out_reg_write, 1);
        chk("addu_count", ov_count, 1);
        tick();

        // stall with out_ready low, then drain in order
        out_ready = 1'b0;
        beat(1'b1, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("stall_ready_after1", in_ready, 1);
        chk("stall_res_after1", out_result, 1);
        beat(1'b1, 32'd2, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        chk("stall_ready_after2", in_ready, 0);
        chk("stall_res_after2", out_result, 1);
        beat(1'b1, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk("stall_hold_ready", in_ready, 0);
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_result", out_result, 1);
        out_ready = 1'b1;
        tick();
        chk("drain_res2", out_result, 2);
        chk("drain_ready2", in_ready, 1);
        tick();
        chk("drain_res3", out_result, 3);
        beat(1'b1, 32'd4, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        chk("drain_res4", out_result, 4);
        beat(1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("drain_empty", out_valid, 0);

        // back-to-back streaming
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 32'(10 + i), 5'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_result", out_result, 64'(10 + i));
        end
        beat(1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stream_end_valid", out_valid, 0);

        // flush while FULL with a trapping beat presented
        out_ready = 1'b0;
        beat(1'b1, 32'd7, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        beat(1'b1, 32'd8, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        chk("flush_pre_ready", in_ready, 0);
        beat(1'b1, 32'd9, 5'd9, 1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        beat(1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_count", ov_count, 1);
        out_ready = 1'b1;
        tick();
        chk("flush_no_beat9", out_valid, 0);

        // counter saturation, then asynchronous reset mid-stream
        rst = 1'b0;
        #2;
        chk("rst2_count", ov_count, 0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 32'h8000_0000, 5'd5, 1'b1, 1'b1, 1'b1);
            tick();
            chk("sat_count", ov_count, (i < 3) ? 64'(i + 1) : 64'd3);
        end
        chk("sat_valid_before_rst", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_count", ov_count, 0);
        chk("async_rst_ready", in_ready, 1);
        chk("async_rst_exc", out_exc, 0);
        beat(1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_result_buffer.md
Name: ex_result_buffer

Overview:
Execute-to-memory stage register directly downstream of the ALU. It captures the ALU Result/Zero/Overflow/CarryOut together with the destination register and write-enable, and applies MIPS overflow-trap suppression. It decouples the execute stage from a stalling memory stage through a 2-entry skid buffer with valid/ready handshakes on both sides, and it keeps a saturating count of trapped overflows.

Parameters:
DATA_WIDTH, 32, width of the ALU result path (4 in the FPGA-board build)
CNT_W, 8, width of the overflow-trap counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  synchronous flush; discards all buffered beats
in_valid  in  1  upstream beat valid
in_ready  out  1  buffer can accept; registered output
in_result  in  DATA_WIDTH  ALU Result
in_zero  in  1  ALU Zero
in_overflow  in  1  ALU Overflow
in_carryout  in  1  ALU CarryOut
in_rd  in  5  destination register number
in_reg_write  in  1  instruction writes the register file
in_trap_ov  in  1  instruction traps on overflow (add/addi/sub)
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts
out_result  out  DATA_WIDTH  buffered Result
out_zero  out  1  buffered Zero
out_carryout  out  1  buffered CarryOut
out_rd  out  5  buffered destination
out_reg_write  out  1  effective write-enable after trap suppression
out_exc  out  1  overflow exception flag for this beat
ov_count  out  CNT_W  saturating count of trapped overflows

Behaviour:
- Reset (rst=0, asynchronous): state EMPTY; out_valid=0; out_result, out_zero, out_carryout, out_rd, out_reg_write and out_exc are 0; in_ready=1; ov_count=0.
- accept = in_valid & in_ready & ~flush. pop = out_valid & out_ready.
- Two storage entries: MAIN drives all out_* ports, SKID holds overflow data. States: EMPTY, ONE, FULL.
- EMPTY: on accept, load MAIN and go to ONE.
- ONE:
  - accept & ~pop: load SKID, go to FULL.
  - accept & pop: reload MAIN from the input, stay in ONE.
  - ~accept & pop: go to EMPTY.
  - Otherwise hold.
- FULL: in_ready=0, so no accept is possible. On pop, MAIN<=SKID and go to ONE. Otherwise hold.
- in_ready is registered: it is 1 in EMPTY and ONE and 0 in FULL, as computed from the next state.
- out_valid is 1 in ONE and FULL.
- Latency is one cycle from accept to out_valid when EMPTY. Sustained throughput is one beat per cycle with out_ready held high.
- While out_valid=1 and out_ready=0, every out_* value stays stable.
- Beat transform, applied at capture time:
  - exc = in_trap_ov & in_overflow.
  - The stored out_exc is exc.
  - The stored out_reg_write is in_reg_write & ~exc.
  - result, zero, carryout and rd are stored unchanged.
  - in_overflow is not forwarded.
- ov_count increments by 1 on each accepted beat with exc=1. It saturates at 2^CNT_W-1 and does not wrap. flush does not clear it.
- flush has priority over accept and pop:
  - The next state is EMPTY, out_valid=0 and in_ready=1 on the next cycle.
  - An input beat presented in the flush cycle is dropped and not counted.
  - A pop handshake occurring in the flush cycle still counts as a transfer downstream, because the out_* values were valid that cycle.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- All arithmetic is unsigned, at CNT_W bits, for the counter only. Data is never modified.

Test Plan:
- Reset, then a single beat (result=32'h0000_0005, rd=3, reg_write=1, trap=0) with out_ready=1 -> out_valid on the next cycle with result 5, rd 3, out_reg_write=1 and out_exc=0; EMPTY afterwards.
- Beat result=32'h8000_0000 with overflow=1 and trap_ov=1 -> out_exc=1, out_reg_write=0 and ov_count=1. The same beat with trap_ov=0 (addu) -> out_exc=0, out_reg_write=1 and ov_count unchanged.
- Stream of 4 beats (values 1..4) with out_ready=0 -> beats 1 and 2 accepted, in_ready=0 from the cycle after the second accept, out_result held at 1. Then raise out_ready -> outputs 1, 2, 3, 4 in order with no loss or duplication.
- Back-to-back beats 10..19 with out_ready=1 continuously -> one output per cycle, each one cycle after its accept, with in_ready constantly 1.
- Buffer FULL (beats 7, 8) while in_valid=1 (beat 9) and flush=1 -> next cycle out_valid=0, in_ready=1, beat 9 absent from the output, ov_count unchanged.
- With CNT_W=2, send 5 trapping overflow beats -> ov_count reads 1, 2, 3, 3, 3. Then assert rst=0 mid-stream -> out_valid=0 and ov_count=0 immediately, before any clock edge.
